// File: rtl/alu_arbiter.sv
// alu_arbiter: a round-robin arbiter that lets two requesters share one combinational 32-bit ALU.
// Only one operation is in flight at a time: IDLE accepts a request, EXEC drives the ALU for one
// cycle, and RESP holds a registered response until the granted requester takes it.
// Ports:
//   clk, reset                                      clock and synchronous active-high reset
//   reqN_valid/ready, reqN_a/b/imm/use_imm/op       operation request channel (N = 0, 1)
//   rspN_valid/ready, rsp_result/zero/err           response channels; the payload is shared
//   alu_srca/regdata2/immext/alusrc/control         registered drive to the ALU
//   alu_result/zero                                 combinational ALU outputs
//   busy, grant_id                                  status: operation in flight, current/last winner
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req0_imm,
  input  logic        req0_use_imm,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [31:0] req1_imm,
  input  logic        req1_use_imm,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [31:0] alu_srca,
  output logic [31:0] alu_regdata2,
  output logic [31:0] alu_immext,
  output logic        alu_alusrc,
  output logic [2:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   prio;     // requester that wins when both are valid
  logic   win;      // IDLE-state winner index
  logic   accept;   // request handshake this cycle
  logic   rsp_hs;   // response handshake on the granted channel

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    rsp_hs     = 1'b0;
    // Contention goes to prio; otherwise whichever side is valid.
    win        = (req0_valid && req1_valid) ? prio : req1_valid;
    case (state)
      IDLE: begin
        // No acceptance while reset is asserted, so nothing is latched and then lost.
        if (!reset) begin
          req0_ready = req0_valid && !win;
          req1_ready = req1_valid && win;
          accept     = req0_ready || req1_ready;
          if (accept) state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp0_valid = !grant_id;
        rsp1_valid = grant_id;
        // The non-granted channel's ready is deliberately ignored.
        rsp_hs     = grant_id ? rsp1_ready : rsp0_ready;
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      prio         <= 1'b0;
      grant_id     <= 1'b0;
      rsp_result   <= 32'd0;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
      alu_srca     <= 32'd0;
      alu_regdata2 <= 32'd0;
      alu_immext   <= 32'd0;
      alu_alusrc   <= 1'b0;
      alu_control  <= 3'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        grant_id     <= win;
        alu_srca     <= win ? req1_a       : req0_a;
        alu_regdata2 <= win ? req1_b       : req0_b;
        alu_immext   <= win ? req1_imm     : req0_imm;
        alu_alusrc   <= win ? req1_use_imm : req0_use_imm;
        alu_control  <= win ? req1_op      : req0_op;
      end
      // The ALU is combinational, so its outputs are valid at the end of EXEC.
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_err    <= (alu_control > 3'b100);
      end
      // The pointer moves only when a response completes; accepting a request leaves it alone.
      if (rsp_hs) prio <= ~grant_id;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_use_imm;
  logic [31:0] req0_a, req0_b, req0_imm;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready, req1_use_imm;
  logic [31:0] req1_a, req1_b, req1_imm;
  logic [2:0]  req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [31:0] alu_srca, alu_regdata2, alu_immext, alu_result;
  logic        alu_alusrc, alu_zero;
  logic [2:0]  alu_control;
  logic        busy, grant_id;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_imm(req0_imm), .req0_use_imm(req0_use_imm), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_imm(req1_imm), .req1_use_imm(req1_use_imm), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_srca(alu_srca), .alu_regdata2(alu_regdata2), .alu_immext(alu_immext),
    .alu_alusrc(alu_alusrc), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .grant_id(grant_id)
  );

  // Shared ALU: add, sub, and, or, xor; any other code yields 0.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_srca, alu_alusrc ? alu_immext : alu_regdata2, alu_control);
  assign alu_zero   = (alu_result == 32'd0);

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  int vectors = 0;
  int miscompares = 0;
  int left0 = 0, left1 = 0;
  bit hs0 = 0, hs1 = 0;
  bit in_exec = 0, rsp_seen = 0;
  int tickn = 0, acc_tick = 0, last_acc = -1, hold = 0, hcnt = 0;
  logic [31:0] x_a, x_b, x_imm;
  logic        x_use;
  logic [2:0]  x_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic use_i, input logic [2:0] op);
    exp_t e;
    e.id   = id;
    e.res  = alu_fn(a, use_i ? imm : b, op);
    e.zero = (e.res == 32'd0);
    e.err  = (op > 3'b100);
    sb.push_back(e);
  endtask

  // Present a payload on requester id for cnt back-to-back operations.
  task automatic drive(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic use_i, input logic [2:0] op, input int cnt);
    if (id) begin
      req1_a = a; req1_b = b; req1_imm = imm; req1_use_imm = use_i; req1_op = op;
      req1_valid = 1'b1; left1 = cnt;
    end else begin
      req0_a = a; req0_b = b; req0_imm = imm; req0_use_imm = use_i; req0_op = op;
      req0_valid = 1'b1; left0 = cnt;
    end
  endtask

  // Observe the window before the next rising edge; inputs are already settled.
  task automatic sample();
    chk("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
    if (in_exec) begin
      in_exec = 0;
      chk("exec_busy", 32'(busy), 32'd1);
      chk("exec_alu_srca", alu_srca, x_a);
      chk("exec_alu_regdata2", alu_regdata2, x_b);
      chk("exec_alu_immext", alu_immext, x_imm);
      chk("exec_alu_alusrc", 32'(alu_alusrc), 32'(x_use));
      chk("exec_alu_control", 32'(alu_control), 32'(x_op));
      chk("exec_no_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
      // A response ready raised outside RESP must have no effect.
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
    end
    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      if (hs1) begin
        x_a = req1_a; x_b = req1_b; x_imm = req1_imm; x_use = req1_use_imm; x_op = req1_op;
      end else begin
        x_a = req0_a; x_b = req0_b; x_imm = req0_imm; x_use = req0_use_imm; x_op = req0_op;
      end
      if (last_acc >= 0) chk("accept_gap", 32'(tickn - last_acc), 32'(3 + hold));
      last_acc = tickn;
      acc_tick = tickn;
      in_exec  = 1;
    end
    if (rsp0_valid || rsp1_valid) begin
      if (!rsp_seen) begin
        rsp_seen = 1;
        hcnt     = hold;
        chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) cur = sb.pop_front();
        chk("rsp_latency", 32'(tickn - acc_tick), 32'd2);
      end
      chk("rsp0_valid", 32'(rsp0_valid), 32'(!cur.id));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(cur.id));
      chk("grant_id", 32'(grant_id), 32'(cur.id));
      chk("rsp_result", rsp_result, cur.res);
      chk("rsp_zero", 32'(rsp_zero), 32'(cur.zero));
      chk("rsp_err", 32'(rsp_err), 32'(cur.err));
      chk("rsp_busy", 32'(busy), 32'd1);
      chk("rsp_no_accept", 32'(req0_ready | req1_ready), 32'd0);
      if (hcnt > 0) begin
        hcnt--;
        // Only the wrong channel says ready while the granted one back-pressures.
        if (cur.id) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      end else begin
        if (cur.id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        rsp_seen = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    tickn++;
    if (hs0) begin hs0 = 0; left0--; if (left0 <= 0) req0_valid = 1'b0; end
    if (hs1) begin hs1 = 0; left1--; if (left1 <= 0) req1_valid = 1'b0; end
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #1;
    sample();
  endtask

  // Run until every queued expectation has been answered, with bounded cycles.
  task automatic run(input int h, input int budget);
    int t;
    t        = 0;
    hold     = h;
    last_acc = -1;
    #1;
    sample();
    while ((sb.size() > 0 || rsp_seen || left0 > 0 || left1 > 0) && t < budget) begin
      tick();
      t++;
    end
    chk("run_outstanding", 32'(sb.size() + left0 + left1), 32'd0);
    tick();
    chk("idle_after_run", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_rsp_valid"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_rsp_flags"}, 32'({rsp_zero, rsp_err}), 32'd0);
    chk({tag, "_alu_srca"}, alu_srca, 32'd0);
    chk({tag, "_alu_regdata2"}, alu_regdata2, 32'd0);
    chk({tag, "_alu_immext"}, alu_immext, 32'd0);
    chk({tag, "_alu_ctl"}, 32'({alu_alusrc, alu_control}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at tick %0d", tickn);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_imm = '0; req0_use_imm = 1'b0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_imm = '0; req1_use_imm = 1'b0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");

    // Both valid straight out of reset: req0 (9-9) first, then req1 (0xF0|0x0F).
    drive(1'b0, 32'd9, 32'd9, 32'h0000DEAD, 1'b0, 3'd1, 1);
    drive(1'b1, 32'h000000F0, 32'h0000000F, 32'h00001234, 1'b0, 3'd3, 1);
    push_exp(1'b0, 32'd9, 32'd9, 32'h0000DEAD, 1'b0, 3'd1);
    push_exp(1'b1, 32'h000000F0, 32'h0000000F, 32'h00001234, 1'b0, 3'd3);
    #1;
    chk("ready_forced_in_reset", 32'({req1_ready, req0_ready}), 32'd0);
    reset = 1'b0;
    run(0, 100);

    // Fairness: both continuously valid for six operations, alternating from req0.
    drive(1'b0, 32'd100, 32'd58, 32'h00000077, 1'b0, 3'd0, 3);
    drive(1'b1, 32'hAAAA5555, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 3'd2, 3);
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, 32'd100, 32'd58, 32'h00000077, 1'b0, 3'd0);
      push_exp(1'b1, 32'hAAAA5555, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 3'd2);
    end
    run(0, 100);

    // Single request: 5 + 7.
    drive(1'b0, 32'd5, 32'd7, 32'h00000099, 1'b0, 3'd0, 1);
    push_exp(1'b0, 32'd5, 32'd7, 32'h00000099, 1'b0, 3'd0);
    run(0, 100);

    // Immediate path with 4 cycles of back-pressure; req0 waits behind req1.
    drive(1'b1, 32'hFFFF0000, 32'h12345678, 32'h0000FFFF, 1'b1, 3'd4, 1);
    drive(1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00000000, 1'b0, 3'd2, 1);
    push_exp(1'b1, 32'hFFFF0000, 32'h12345678, 32'h0000FFFF, 1'b1, 3'd4);
    push_exp(1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00000000, 1'b0, 3'd2);
    run(4, 100);

    // Illegal op code.
    drive(1'b0, 32'h00000011, 32'h00000022, 32'h00000033, 1'b0, 3'b110, 1);
    push_exp(1'b0, 32'h00000011, 32'h00000022, 32'h00000033, 1'b0, 3'b110);
    run(0, 100);

    // Reset one cycle after accept: the operation is dropped.
    hold = 0;
    last_acc = -1;
    drive(1'b0, 32'h00000040, 32'h00000002, 32'h00000000, 1'b0, 3'd0, 1);
    #1;
    sample();
    chk("pre_reset_accept", 32'(hs0), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b0; hs0 = 0; left0 = 0; in_exec = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dropped_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    end

    // prio must be back at 0: req0 wins the contention.
    drive(1'b0, 32'd1, 32'd2, 32'h00000005, 1'b0, 3'd0, 1);
    drive(1'b1, 32'd3, 32'd3, 32'h00000006, 1'b0, 3'd1, 1);
    push_exp(1'b0, 32'd1, 32'd2, 32'h00000005, 1'b0, 3'd0);
    push_exp(1'b1, 32'd3, 32'd3, 32'h00000006, 1'b0, 3'd1);
    run(0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
